// File: rtl/mem_wb_stage_if.sv
// rtl/mem_wb_stage_if.sv - ALU-stage result record and 8-bit request/acknowledge memory bus
typedef struct packed {
    logic [15:0] data_out;
    logic [1:0]  reg_write;
    logic [2:0]  reg_dest;
    logic        setPC;
    logic [1:0]  mem_read;
    logic [1:0]  mem_write;
    logic [15:0] mem_addr;
} alu_signals;

interface mem_wb_stage_if;
    logic        bus_req;
    logic        bus_we;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata;
    logic        bus_ack;

    // The stage issues beats; the memory answers with data and acknowledge.
    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_rdata, bus_ack
    );
endinterface

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - memory access over a byte-wide beat bus followed by register/PC writeback
module mem_wb_stage (
    input  logic           clk,
    input  logic           reset,
    input  logic           en,
    input  alu_signals     control_signals_in,
    mem_wb_stage_if.master bus,
    output logic [1:0]     rf_write,
    output logic [2:0]     rf_dest,
    output logic [15:0]    rf_data,
    output logic           pc_write,
    output logic [15:0]    pc_data,
    output logic           busy,
    output logic           done
);

    typedef enum logic [1:0] {IDLE, BEAT_LO, BEAT_HI, WB} state_t;

    state_t      state_q, state_d;
    alu_signals  op_q, op_d;
    logic [7:0]  lo_q, lo_d;
    logic [7:0]  hi_q, hi_d;

    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [15:0] bus_addr_q, bus_addr_d;
    logic [7:0]  bus_wdata_q, bus_wdata_d;
    logic [1:0]  rf_write_q, rf_write_d;
    logic [2:0]  rf_dest_q, rf_dest_d;
    logic [15:0] rf_data_q, rf_data_d;
    logic        pc_write_q, pc_write_d;
    logic [15:0] pc_data_q, pc_data_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        is_write;
    logic        is_load;
    logic        is_word;
    logic        ack_ok;

    // An acknowledge only counts while a request is actually on the bus.
    assign ack_ok = bus.bus_ack & bus_req_q;

    // State, latched operation, captured read bytes and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            op_q        <= '0;
            lo_q        <= '0;
            hi_q        <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            rf_write_q  <= '0;
            rf_dest_q   <= '0;
            rf_data_q   <= '0;
            pc_write_q  <= 1'b0;
            pc_data_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            rf_write_q  <= rf_write_d;
            rf_dest_q   <= rf_dest_d;
            rf_data_q   <= rf_data_d;
            pc_write_q  <= pc_write_d;
            pc_data_q   <= pc_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Next state, then outputs decoded from the state being entered so each
    // output register already holds the values of the state it accompanies.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        lo_d    = lo_q;
        hi_d    = hi_q;

        if (state_q == IDLE && en) begin
            op_d = control_signals_in;
        end

        // A store wins over a load when both are requested.
        is_write = op_d.mem_write[0];
        is_load  = ~op_d.mem_write[0] & op_d.mem_read[0];
        is_word  = is_write ? op_d.mem_write[1] : op_d.mem_read[1];

        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = (is_write || is_load) ? BEAT_LO : WB;
                end
            end
            BEAT_LO: begin
                if (ack_ok) begin
                    if (is_load) begin
                        lo_d = bus.bus_rdata;
                    end
                    state_d = is_word ? BEAT_HI : WB;
                end
            end
            BEAT_HI: begin
                if (ack_ok) begin
                    if (is_load) begin
                        hi_d = bus.bus_rdata;
                    end
                    state_d = WB;
                end
            end
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase

        bus_req_d   = 1'b0;
        bus_we_d    = 1'b0;
        bus_addr_d  = '0;
        bus_wdata_d = '0;
        rf_write_d  = '0;
        rf_dest_d   = '0;
        rf_data_d   = '0;
        pc_write_d  = 1'b0;
        pc_data_d   = '0;
        done_d      = 1'b0;
        busy_d      = (state_d != IDLE);

        case (state_d)
            BEAT_LO: begin
                bus_req_d   = 1'b1;
                bus_we_d    = is_write;
                bus_addr_d  = op_d.mem_addr;
                bus_wdata_d = op_d.data_out[7:0];
            end
            BEAT_HI: begin
                bus_req_d   = 1'b1;
                bus_we_d    = is_write;
                bus_addr_d  = op_d.mem_addr + 16'd1;
                bus_wdata_d = op_d.data_out[15:8];
            end
            WB: begin
                done_d     = 1'b1;
                rf_write_d = op_d.reg_write;
                rf_dest_d  = op_d.reg_dest;
                pc_write_d = op_d.setPC;
                pc_data_d  = op_d.data_out;
                // A byte load is mirrored into both lanes so either byte enable picks it up.
                if (is_load) begin
                    rf_data_d = is_word ? {hi_d, lo_d} : {lo_d, lo_d};
                end else begin
                    rf_data_d = op_d.data_out;
                end
            end
            default: begin
            end
        endcase
    end

    assign bus.bus_req   = bus_req_q;
    assign bus.bus_we    = bus_we_q;
    assign bus.bus_addr  = bus_addr_q;
    assign bus.bus_wdata = bus_wdata_q;
    assign rf_write      = rf_write_q;
    assign rf_dest       = rf_dest_q;
    assign rf_data       = rf_data_q;
    assign pc_write      = pc_write_q;
    assign pc_data       = pc_data_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - directed vector bench for mem_wb_stage
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    alu_signals  ctrl;
    logic [1:0]  rf_write;
    logic [2:0]  rf_dest;
    logic [15:0] rf_data;
    logic        pc_write;
    logic [15:0] pc_data;
    logic        busy;
    logic        done;

    mem_wb_stage_if bus_if ();

    mem_wb_stage dut (
        .clk                (clk),
        .reset              (reset),
        .en                 (en),
        .control_signals_in (ctrl),
        .bus                (bus_if.master),
        .rf_write           (rf_write),
        .rf_dest            (rf_dest),
        .rf_data            (rf_data),
        .pc_write           (pc_write),
        .pc_data            (pc_data),
        .busy               (busy),
        .done               (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        alu_signals  ctrl;
        int          delay;
        logic [7:0]  rd_lo;
        logic [7:0]  rd_hi;
        int          n_beats;
        logic [15:0] a0;
        logic [15:0] a1;
        logic        we;
        logic [7:0]  w0;
        logic [7:0]  w1;
        logic [1:0]  e_rfw;
        logic [2:0]  e_dest;
        logic [15:0] e_rfd;
        logic        e_pcw;
        logic [15:0] e_pcd;
        int          lat;
    } vec_t;

    int checks = 0;
    int passes = 0;
    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic vec_t mk(input string nm, input logic [15:0] d, input logic [1:0] rw,
                                input logic [2:0] dst, input logic spc, input logic [1:0] mr,
                                input logic [1:0] mw, input logic [15:0] addr, input int dly,
                                input logic [7:0] lo, input logic [7:0] hi, input int nb,
                                input logic [15:0] a0, input logic [15:0] a1, input logic we,
                                input logic [7:0] w0, input logic [7:0] w1, input logic [15:0] erd,
                                input int lat);
        vec_t v;
        v.name = nm;
        v.ctrl.data_out  = d;
        v.ctrl.reg_write = rw;
        v.ctrl.reg_dest  = dst;
        v.ctrl.setPC     = spc;
        v.ctrl.mem_read  = mr;
        v.ctrl.mem_write = mw;
        v.ctrl.mem_addr  = addr;
        v.delay = dly;   v.rd_lo = lo;   v.rd_hi = hi;
        v.n_beats = nb;  v.a0 = a0;      v.a1 = a1;
        v.we = we;       v.w0 = w0;      v.w1 = w1;
        v.e_rfw = rw;    v.e_dest = dst; v.e_rfd = erd;
        v.e_pcw = spc;   v.e_pcd = d;    v.lat = lat;
        return v;
    endfunction

    // Called at a negedge: issues one op, plays the memory side, checks writeback and beats.
    task automatic run_vec(input vec_t v);
        logic [15:0] ba[2];
        logic        bwe[2];
        logic [7:0]  bwd[2];
        logic [1:0]  c_rfw = '0;
        logic [2:0]  c_dest = '0;
        logic [15:0] c_rfd = '0;
        logic        c_pcw = 1'b0;
        logic [15:0] c_pcd = '0;
        int nb = 0;
        int rec = 0;
        int w = 0;
        int lat = 0;
        bit seen = 1'b0;
        bit stray = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ba[i] = '0; bwe[i] = 1'b0; bwd[i] = '0;
        end
        ctrl = v.ctrl;
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        for (int cyc = 1; cyc <= 40 && !seen; cyc++) begin
            bus_if.bus_ack = 1'b0;
            if (done) begin
                seen = 1'b1;
                lat = cyc;
                c_rfw = rf_write; c_dest = rf_dest; c_rfd = rf_data;
                c_pcw = pc_write; c_pcd = pc_data;
            end else begin
                if (rf_write != 2'b00 || pc_write) stray = 1'b1;
                if (bus_if.bus_req) begin
                    if (w == 0) begin
                        if (rec < 2) begin
                            ba[rec] = bus_if.bus_addr;
                            bwe[rec] = bus_if.bus_we;
                            bwd[rec] = bus_if.bus_wdata;
                        end
                        rec++;
                    end
                    if (w == v.delay) begin
                        bus_if.bus_ack = 1'b1;
                        bus_if.bus_rdata = (nb == 0) ? v.rd_lo : v.rd_hi;
                        nb++;
                        w = 0;
                    end else begin
                        w++;
                    end
                end
            end
            @(negedge clk);
        end
        bus_if.bus_ack = 1'b0;
        check({v.name, " done_seen"}, 32'(seen), 32'd1);
        check({v.name, " beats"}, 32'(rec), 32'(v.n_beats));
        if (v.n_beats >= 1) begin
            check({v.name, " beat0_addr"}, 32'(ba[0]), 32'(v.a0));
            check({v.name, " beat0_we"}, 32'(bwe[0]), 32'(v.we));
            if (v.we) check({v.name, " beat0_wdata"}, 32'(bwd[0]), 32'(v.w0));
        end
        if (v.n_beats >= 2) begin
            check({v.name, " beat1_addr"}, 32'(ba[1]), 32'(v.a1));
            check({v.name, " beat1_we"}, 32'(bwe[1]), 32'(v.we));
            if (v.we) check({v.name, " beat1_wdata"}, 32'(bwd[1]), 32'(v.w1));
        end
        check({v.name, " rf_write"}, 32'(c_rfw), 32'(v.e_rfw));
        check({v.name, " rf_dest"}, 32'(c_dest), 32'(v.e_dest));
        check({v.name, " rf_data"}, 32'(c_rfd), 32'(v.e_rfd));
        check({v.name, " pc_write"}, 32'(c_pcw), 32'(v.e_pcw));
        check({v.name, " pc_data"}, 32'(c_pcd), 32'(v.e_pcd));
        check({v.name, " latency"}, 32'(lat), 32'(v.lat));
        check({v.name, " no_early_write"}, 32'(stray), 32'd0);
        check({v.name, " done_one_cycle"}, 32'(done), 32'd0);
        check({v.name, " busy_after"}, 32'(busy), 32'd0);
        check({v.name, " rf_write_after"}, 32'(rf_write), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n_done;
        int n_pcw;
        int n_rfw;
        int n_req;

        //          name        data      rw     dst   pc  mr     mw     addr      dly lo     hi     nb a0        a1        we  w0     w1     rf_data   lat
        vecs[0] = mk("alu_only", 16'h1234, 2'b11, 3'd5, 0, 2'b00, 2'b00, 16'h0000, 0, 8'h00, 8'h00, 0, 16'h0000, 16'h0000, 0, 8'h00, 8'h00, 16'h1234, 1);
        vecs[1] = mk("word_ld",  16'h5555, 2'b11, 3'd2, 0, 2'b11, 2'b00, 16'hFFFF, 2, 8'hCD, 8'hAB, 2, 16'hFFFF, 16'h0000, 0, 8'h00, 8'h00, 16'hABCD, 7);
        vecs[2] = mk("word_st",  16'hBEEF, 2'b00, 3'd0, 0, 2'b00, 2'b11, 16'h0100, 0, 8'h00, 8'h00, 2, 16'h0100, 16'h0101, 1, 8'hEF, 8'hBE, 16'hBEEF, 3);
        vecs[3] = mk("set_pc",   16'h0042, 2'b00, 3'd0, 1, 2'b00, 2'b00, 16'h0000, 0, 8'h00, 8'h00, 0, 16'h0000, 16'h0000, 0, 8'h00, 8'h00, 16'h0042, 1);
        vecs[4] = mk("byte_ld",  16'h1111, 2'b01, 3'd3, 0, 2'b01, 2'b00, 16'h2000, 1, 8'h7E, 8'h00, 1, 16'h2000, 16'h0000, 0, 8'h00, 8'h00, 16'h7E7E, 3);
        vecs[5] = mk("wr_wins",  16'h00A5, 2'b10, 3'd7, 0, 2'b11, 2'b01, 16'h3FFF, 0, 8'h00, 8'h00, 1, 16'h3FFF, 16'h0000, 1, 8'hA5, 8'h00, 16'h00A5, 2);
        vecs[6] = mk("byte_st",  16'h1299, 2'b00, 3'd0, 0, 2'b00, 2'b01, 16'h0010, 0, 8'h00, 8'h00, 1, 16'h0010, 16'h0000, 1, 8'h99, 8'h00, 16'h1299, 2);

        // Reset held two cycles with a stray acknowledge on the bus.
        reset = 1'b1;
        en = 1'b0;
        ctrl = '0;
        bus_if.bus_ack = 1'b1;
        bus_if.bus_rdata = 8'hFF;
        @(negedge clk);
        @(negedge clk);
        check("rst bus_req", 32'(bus_if.bus_req), 32'd0);
        check("rst bus_we", 32'(bus_if.bus_we), 32'd0);
        check("rst bus_addr", 32'(bus_if.bus_addr), 32'd0);
        check("rst bus_wdata", 32'(bus_if.bus_wdata), 32'd0);
        check("rst rf_write", 32'(rf_write), 32'd0);
        check("rst rf_dest", 32'(rf_dest), 32'd0);
        check("rst rf_data", 32'(rf_data), 32'd0);
        check("rst pc_write", 32'(pc_write), 32'd0);
        check("rst pc_data", 32'(pc_data), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        reset = 1'b0;
        bus_if.bus_ack = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i]);
        end

        // en held into the WB cycle must be ignored: exactly one writeback.
        ctrl = vecs[3].ctrl;
        en = 1'b1;
        @(negedge clk);
        check("busy_en busy_in_wb", 32'(busy), 32'd1);
        n_done = 0; n_pcw = 0; n_rfw = 0;
        for (int c = 0; c < 8; c++) begin
            if (done) n_done++;
            if (pc_write) n_pcw++;
            if (rf_write != 2'b00) n_rfw++;
            @(negedge clk);
            en = 1'b0;
        end
        check("busy_en done_count", 32'(n_done), 32'd1);
        check("busy_en pc_write_count", 32'(n_pcw), 32'd1);
        check("busy_en rf_write_count", 32'(n_rfw), 32'd0);

        // Reset during the low beat of a byte load, then a late acknowledge.
        ctrl = vecs[4].ctrl;
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        check("mid_rst req_before", 32'(bus_if.bus_req), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst req_dropped", 32'(bus_if.bus_req), 32'd0);
        check("mid_rst busy", 32'(busy), 32'd0);
        bus_if.bus_ack = 1'b1;
        bus_if.bus_rdata = 8'h55;
        n_done = 0; n_rfw = 0; n_req = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (done) n_done++;
            if (rf_write != 2'b00) n_rfw++;
            if (bus_if.bus_req) n_req++;
        end
        bus_if.bus_ack = 1'b0;
        check("mid_rst done_count", 32'(n_done), 32'd0);
        check("mid_rst rf_write_count", 32'(n_rfw), 32'd0);
        check("mid_rst req_count", 32'(n_req), 32'd0);
        check("mid_rst idle_busy", 32'(busy), 32'd0);
        @(negedge clk);

        // A normal byte load still completes afterwards.
        run_vec(vecs[4]);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
